// File: rtl/cnn_layer_accel_awe_feeder_pkg.sv
// Shared constants and helpers for the AWE feeder.
// Holds the FSM state encoding, default sizing of the kernel/window/drain
// logic, the lane widths of the 4-lane pixel and weight beats, and a
// helper that turns a kernel size K into its tap count K*K.
package cnn_layer_accel_awe_feeder_pkg;

  localparam int C_MAX_KERNAL_DEF    = 5;
  localparam int C_WIN_CNT_WIDTH_DEF = 16;
  localparam int C_DRAIN_CYCLES_DEF  = 8;
  localparam int C_KERNAL_SIZE_WIDTH = 4;

  localparam int PIXEL_WIDTH      = 16;
  localparam int WEIGHT_WIDTH     = 16;
  localparam int C_PIX_BEAT_WIDTH = 4 * PIXEL_WIDTH;
  localparam int C_WHT_BEAT_WIDTH = 4 * WEIGHT_WIDTH;

  // FSM state encoding
  typedef logic [1:0] feeder_state_t;
  localparam feeder_state_t ST_IDLE     = 2'd0;
  localparam feeder_state_t ST_LOAD_WHT = 2'd1;
  localparam feeder_state_t ST_STREAM   = 2'd2;
  localparam feeder_state_t ST_DRAIN    = 2'd3;

  // Taps per window (K*K) at double width so that no product is lost
  function automatic logic [2*C_KERNAL_SIZE_WIDTH-1:0] kernel_taps(
    input logic [C_KERNAL_SIZE_WIDTH-1:0] k
  );
    logic [2*C_KERNAL_SIZE_WIDTH-1:0] kx;
    kx = {{C_KERNAL_SIZE_WIDTH{1'b0}}, k};
    return kx * kx;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_awe_wht_buf.sv
// Kernel weight buffer for the AWE feeder.
// DEPTH x DW distributed RAM: one synchronous write port and one
// asynchronous read port. The contents are deliberately not reset; every
// map reloads the buffer before it is read.
// Ports:
//   clk_i      clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data (one 4-lane weight beat)
//   rd_addr_i  read address (combinational read)
//   rd_data_o  read data
import cnn_layer_accel_awe_feeder_pkg::*;

module cnn_layer_accel_awe_wht_buf #(
  parameter int DEPTH = C_MAX_KERNAL_DEF * C_MAX_KERNAL_DEF,
  parameter int AW    = $clog2(DEPTH + 1),
  parameter int DW    = C_WHT_BEAT_WIDTH
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/cnn_layer_accel_awe_feeder.sv
// Transmit side of the AWE DSP pixel/weight interface.
// Preloads the K*K weight beats of a kernel, then streams pixel beats, each
// paired with the weight of its tap, to the ce0/ce1 lanes of the DSP pair.
// There is no backpressure from the DSPs; a missing pixel beat produces a
// bubble with all valids low and the data lanes held.
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   new_map_i                      start pulse (latches K and window count)
//   kernal_window_size_i           K, taps per window = K*K
//   num_windows_i                  windows in this map
//   wht_valid_i/wht_ready_o        weight beat handshake, wht_datain_i data
//   pix_valid_i/pix_ready_o        pixel beat handshake, pix_datain_i data
//   ce{0,1}_{pixel,weight}_*_o     DSP lanes, {up,lo} per CE
//   busy_o                         map in progress
//   map_done_o                     one-cycle completion pulse
import cnn_layer_accel_awe_feeder_pkg::*;

module cnn_layer_accel_awe_feeder #(
  parameter int C_MAX_KERNAL    = C_MAX_KERNAL_DEF,
  parameter int C_WIN_CNT_WIDTH = C_WIN_CNT_WIDTH_DEF,
  parameter int C_DRAIN_CYCLES  = C_DRAIN_CYCLES_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           new_map_i,
  input  logic [C_KERNAL_SIZE_WIDTH-1:0] kernal_window_size_i,
  input  logic [C_WIN_CNT_WIDTH-1:0]     num_windows_i,
  input  logic                           wht_valid_i,
  output logic                           wht_ready_o,
  input  logic [C_WHT_BEAT_WIDTH-1:0]    wht_datain_i,
  input  logic                           pix_valid_i,
  output logic                           pix_ready_o,
  input  logic [C_PIX_BEAT_WIDTH-1:0]    pix_datain_i,
  output logic                           ce0_pixel_valid_o,
  output logic [2*PIXEL_WIDTH-1:0]       ce0_pixel_datain_o,
  output logic                           ce1_pixel_valid_o,
  output logic [2*PIXEL_WIDTH-1:0]       ce1_pixel_datain_o,
  output logic                           ce0_weight_valid_o,
  output logic [2*WEIGHT_WIDTH-1:0]      ce0_weight_datain_o,
  output logic                           ce1_weight_valid_o,
  output logic [2*WEIGHT_WIDTH-1:0]      ce1_weight_datain_o,
  output logic                           busy_o,
  output logic                           map_done_o
);

  localparam int KKW   = $clog2(C_MAX_KERNAL * C_MAX_KERNAL + 1);
  localparam int DRW   = $clog2(C_DRAIN_CYCLES + 1);
  localparam int WW    = C_WIN_CNT_WIDTH;
  localparam int KW    = C_KERNAL_SIZE_WIDTH;

  feeder_state_t              state_q, state_d;
  logic [KKW-1:0]             kk_q, kk_d;
  logic [WW-1:0]              nw_q, nw_d;
  logic [KKW-1:0]             wr_addr_q, wr_addr_d;
  logic [KKW-1:0]             tap_q, tap_d;
  logic [WW-1:0]              win_q, win_d;
  logic [DRW-1:0]             drain_q, drain_d;
  logic                       wht_ready_q, wht_ready_d;
  logic                       pix_ready_q, pix_ready_d;
  logic                       valid_q, valid_d;
  logic [C_PIX_BEAT_WIDTH-1:0] pix_data_q, pix_data_d;
  logic [C_WHT_BEAT_WIDTH-1:0] wht_data_q, wht_data_d;
  logic                       busy_q, busy_d;
  logic                       map_done_q, map_done_d;

  logic                        cfg_ok_s;
  logic                        wr_en_s;
  logic [C_WHT_BEAT_WIDTH-1:0] rd_data_s;

  cnn_layer_accel_awe_wht_buf #(
    .DEPTH (C_MAX_KERNAL * C_MAX_KERNAL),
    .AW    (KKW),
    .DW    (C_WHT_BEAT_WIDTH)
  ) u_wht_buf (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_addr_q),
    .wr_data_i (wht_datain_i),
    .rd_addr_i (tap_q),
    .rd_data_o (rd_data_s)
  );

  assign cfg_ok_s = (kernal_window_size_i != {KW{1'b0}}) &&
                    (kernal_window_size_i <= KW'(C_MAX_KERNAL)) &&
                    (num_windows_i != {WW{1'b0}});

  // Next-state logic for the FSM, counters and output registers
  always_comb begin
    state_d     = state_q;
    kk_d        = kk_q;
    nw_d        = nw_q;
    wr_addr_d   = wr_addr_q;
    tap_d       = tap_q;
    win_d       = win_q;
    drain_d     = drain_q;
    wht_ready_d = wht_ready_q;
    pix_ready_d = pix_ready_q;
    valid_d     = 1'b0;
    pix_data_d  = pix_data_q;
    wht_data_d  = wht_data_q;
    busy_d      = busy_q;
    map_done_d  = 1'b0;
    wr_en_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the completion pulse is dropped.
        if (new_map_i && !map_done_q) begin
          kk_d      = KKW'(kernel_taps(kernal_window_size_i));
          nw_d      = num_windows_i;
          wr_addr_d = {KKW{1'b0}};
          tap_d     = {KKW{1'b0}};
          win_d     = {WW{1'b0}};
          drain_d   = {DRW{1'b0}};
          if (cfg_ok_s) begin
            state_d     = ST_LOAD_WHT;
            busy_d      = 1'b1;
            wht_ready_d = 1'b1;
          end else begin
            // Illegal config: complete immediately without any handshake.
            map_done_d = 1'b1;
            busy_d     = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_WHT: begin
        if (wht_valid_i && wht_ready_q) begin
          wr_en_s = 1'b1;
          if (wr_addr_q == kk_q - KKW'(1)) begin
            state_d     = ST_STREAM;
            wht_ready_d = 1'b0;
            pix_ready_d = 1'b1;
            tap_d       = {KKW{1'b0}};
            win_d       = {WW{1'b0}};
          end else begin
            wr_addr_d = wr_addr_q + KKW'(1);
          end
        end else begin
          wr_addr_d = wr_addr_q;
        end
      end
      ST_STREAM: begin
        if (pix_valid_i && pix_ready_q) begin
          valid_d    = 1'b1;
          pix_data_d = pix_datain_i;
          wht_data_d = rd_data_s;
          if (tap_q == kk_q - KKW'(1)) begin
            tap_d = {KKW{1'b0}};
            if (win_q == nw_q - WW'(1)) begin
              state_d     = ST_DRAIN;
              pix_ready_d = 1'b0;
              drain_d     = {DRW{1'b0}};
            end else begin
              win_d = win_q + WW'(1);
            end
          end else begin
            tap_d = tap_q + KKW'(1);
          end
        end else begin
          tap_d = tap_q;
        end
      end
      ST_DRAIN: begin
        // Drain counts from the edge that produced the last valid beat.
        if (drain_q == DRW'(C_DRAIN_CYCLES - 1)) begin
          state_d    = ST_IDLE;
          map_done_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          drain_d = drain_q + DRW'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        wht_ready_d = 1'b0;
        pix_ready_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      kk_q        <= {KKW{1'b0}};
      nw_q        <= {WW{1'b0}};
      wr_addr_q   <= {KKW{1'b0}};
      tap_q       <= {KKW{1'b0}};
      win_q       <= {WW{1'b0}};
      drain_q     <= {DRW{1'b0}};
      wht_ready_q <= 1'b0;
      pix_ready_q <= 1'b0;
      valid_q     <= 1'b0;
      pix_data_q  <= {C_PIX_BEAT_WIDTH{1'b0}};
      wht_data_q  <= {C_WHT_BEAT_WIDTH{1'b0}};
      busy_q      <= 1'b0;
      map_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      kk_q        <= kk_d;
      nw_q        <= nw_d;
      wr_addr_q   <= wr_addr_d;
      tap_q       <= tap_d;
      win_q       <= win_d;
      drain_q     <= drain_d;
      wht_ready_q <= wht_ready_d;
      pix_ready_q <= pix_ready_d;
      valid_q     <= valid_d;
      pix_data_q  <= pix_data_d;
      wht_data_q  <= wht_data_d;
      busy_q      <= busy_d;
      map_done_q  <= map_done_d;
    end
  end

  assign wht_ready_o         = wht_ready_q;
  assign pix_ready_o         = pix_ready_q;
  assign ce0_pixel_valid_o   = valid_q;
  assign ce1_pixel_valid_o   = valid_q;
  assign ce0_weight_valid_o  = valid_q;
  assign ce1_weight_valid_o  = valid_q;
  // Fixed lane split; the receiver applies any inter-DSP skew.
  assign ce1_pixel_datain_o  = pix_data_q[4*PIXEL_WIDTH-1:2*PIXEL_WIDTH];
  assign ce0_pixel_datain_o  = pix_data_q[2*PIXEL_WIDTH-1:0];
  assign ce1_weight_datain_o = wht_data_q[4*WEIGHT_WIDTH-1:2*WEIGHT_WIDTH];
  assign ce0_weight_datain_o = wht_data_q[2*WEIGHT_WIDTH-1:0];
  assign busy_o              = busy_q;
  assign map_done_o          = map_done_q;

endmodule

// File: tb/tb_cnn_layer_accel_awe_feeder.sv
// Directed self-checking bench for cnn_layer_accel_awe_feeder.
module tb_cnn_layer_accel_awe_feeder;

  logic        clk;
  logic        rst_n;
  logic        new_map;
  logic [3:0]  kernal_window_size;
  logic [15:0] num_windows;
  logic        wht_valid;
  logic        wht_ready;
  logic [63:0] wht_datain;
  logic        pix_valid;
  logic        pix_ready;
  logic [63:0] pix_datain;
  logic        ce0_pixel_valid, ce1_pixel_valid, ce0_weight_valid, ce1_weight_valid;
  logic [31:0] ce0_pixel_datain, ce1_pixel_datain, ce0_weight_datain, ce1_weight_datain;
  logic        busy;
  logic        map_done;

  int total = 0;
  int bad   = 0;

  cnn_layer_accel_awe_feeder dut (
    .clk_i                (clk),
    .rst_n_i              (rst_n),
    .new_map_i            (new_map),
    .kernal_window_size_i (kernal_window_size),
    .num_windows_i        (num_windows),
    .wht_valid_i          (wht_valid),
    .wht_ready_o          (wht_ready),
    .wht_datain_i         (wht_datain),
    .pix_valid_i          (pix_valid),
    .pix_ready_o          (pix_ready),
    .pix_datain_i         (pix_datain),
    .ce0_pixel_valid_o    (ce0_pixel_valid),
    .ce0_pixel_datain_o   (ce0_pixel_datain),
    .ce1_pixel_valid_o    (ce1_pixel_valid),
    .ce1_pixel_datain_o   (ce1_pixel_datain),
    .ce0_weight_valid_o   (ce0_weight_valid),
    .ce0_weight_datain_o  (ce0_weight_datain),
    .ce1_weight_valid_o   (ce1_weight_valid),
    .ce1_weight_datain_o  (ce1_weight_datain),
    .busy_o               (busy),
    .map_done_o           (map_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wbeat(input int s, input int i);
    logic [15:0] b;
    b = 16'((s << 8) + i);
    return {b ^ 16'h3000, b ^ 16'h2000, b ^ 16'h1000, b};
  endfunction

  function automatic logic [63:0] pbeat(input int s, input int n);
    logic [15:0] b;
    b = 16'((s << 8) + n);
    return {b ^ 16'hF000, b ^ 16'hE000, b ^ 16'hD000, b ^ 16'hC000};
  endfunction

  function automatic logic [3:0] valids();
    return {ce1_pixel_valid, ce0_pixel_valid, ce1_weight_valid, ce0_weight_valid};
  endfunction

  // Full map: weight load, stream (optionally alternating bubbles), drain.
  // noise holds new_map and wht_valid high where they must be ignored.
  task automatic run_map(input int k, input int nw, input bit alt, input bit noise, input int seed);
    int kk;
    int n;
    int cyc;
    int c;
    bit v;
    bit done;
    logic [63:0] pb, wb, last_pb, last_wb;
    kk = k * k;
    kernal_window_size = 4'(k);
    num_windows = 16'(nw);
    new_map = 1'b1;
    step();
    if (noise) begin
      kernal_window_size = 4'd1;
      num_windows = 16'd5;
    end else begin
      new_map = 1'b0;
    end
    check_eq("start_busy", 64'(busy), 64'd1);
    check_eq("start_wht_ready", 64'(wht_ready), 64'd1);
    for (int i = 0; i < kk; i++) begin
      wht_valid = 1'b1;
      wht_datain = wbeat(seed, i);
      step();
    end
    wht_valid = noise;
    check_eq("load_end_wht_ready", 64'(wht_ready), 64'd0);
    check_eq("load_end_pix_ready", 64'(pix_ready), 64'd1);
    n = 0;
    cyc = 0;
    last_pb = 64'd0;
    last_wb = 64'd0;
    while (n < kk * nw && cyc < 200) begin
      v = alt ? ((cyc % 2) == 0) : 1'b1;
      pix_valid = v;
      pix_datain = pbeat(seed, n);
      step();
      if (v) begin
        pb = pbeat(seed, n);
        wb = wbeat(seed, n % kk);
        check_eq("beat_valids", 64'(valids()), 64'hF);
        check_eq("ce1_pixel", 64'(ce1_pixel_datain), 64'(pb[63:32]));
        check_eq("ce0_pixel", 64'(ce0_pixel_datain), 64'(pb[31:0]));
        check_eq("ce1_weight", 64'(ce1_weight_datain), 64'(wb[63:32]));
        check_eq("ce0_weight", 64'(ce0_weight_datain), 64'(wb[31:0]));
        last_pb = pb;
        last_wb = wb;
        n++;
      end else begin
        check_eq("bubble_valids", 64'(valids()), 64'h0);
        check_eq("bubble_pix_hold", {ce1_pixel_datain, ce0_pixel_datain}, last_pb);
        check_eq("bubble_wht_hold", {ce1_weight_datain, ce0_weight_datain}, last_wb);
      end
      if (noise) check_eq("stream_wht_ready", 64'(wht_ready), 64'd0);
      cyc++;
    end
    pix_valid = 1'b0;
    check_eq("stream_beats", 64'(n), 64'(kk * nw));
    check_eq("stream_end_pix_ready", 64'(pix_ready), 64'd0);
    c = 0;
    done = 1'b0;
    while (!done && c < 40) begin
      step();
      c++;
      if (map_done) begin
        done = 1'b1;
      end else begin
        check_eq("drain_busy", 64'(busy), 64'd1);
        check_eq("drain_valids", 64'(valids()), 64'h0);
      end
    end
    check_eq("drain_len", 64'(c), 64'd8);
    check_eq("done_busy", 64'(busy), 64'd0);
    step();
    check_eq("done_pulse_width", 64'(map_done), 64'd0);
    if (noise) begin
      check_eq("ignored_new_map_busy", 64'(busy), 64'd0);
      check_eq("ignored_new_map_ready", 64'(wht_ready), 64'd0);
    end
    new_map = 1'b0;
    wht_valid = 1'b0;
  endtask

  task automatic bad_cfg(input int k, input int nw);
    kernal_window_size = 4'(k);
    num_windows = 16'(nw);
    new_map = 1'b1;
    step();
    new_map = 1'b0;
    check_eq("bad_cfg_done", 64'(map_done), 64'd1);
    check_eq("bad_cfg_busy", 64'(busy), 64'd0);
    check_eq("bad_cfg_ready", {62'd0, wht_ready, pix_ready}, 64'd0);
    step();
    check_eq("bad_cfg_done_clr", 64'(map_done), 64'd0);
    check_eq("bad_cfg_ready2", {62'd0, wht_ready, pix_ready}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {valids(), 2'b00, wht_ready, pix_ready, busy, map_done}, 64'd0);
    check_eq(tag, {ce1_pixel_datain, ce0_pixel_datain}, 64'd0);
    check_eq(tag, {ce1_weight_datain, ce0_weight_datain}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    new_map = 1'b0;
    kernal_window_size = 4'd0;
    num_windows = 16'd0;
    wht_valid = 1'b0;
    wht_datain = 64'd0;
    pix_valid = 1'b0;
    pix_datain = 64'd0;
    #3;
    check_all_zero("reset_state");
    step();
    step();
    rst_n = 1'b1;
    step();

    run_map(3, 2, 1'b0, 1'b0, 1);
    run_map(3, 2, 1'b1, 1'b0, 2);
    run_map(1, 1, 1'b0, 1'b0, 3);
    bad_cfg(0, 2);
    bad_cfg(6, 2);
    bad_cfg(3, 0);

    // Reset in the middle of the stream, right after tap 3 went out.
    kernal_window_size = 4'd3;
    num_windows = 16'd2;
    new_map = 1'b1;
    step();
    new_map = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wht_valid = 1'b1;
      wht_datain = wbeat(4, i);
      step();
    end
    wht_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1;
      pix_datain = pbeat(4, i);
      step();
    end
    check_eq("pre_reset_valids", 64'(valids()), 64'hF);
    pix_datain = pbeat(4, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    #2;
    pix_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check_all_zero("post_reset_idle");

    run_map(3, 2, 1'b0, 1'b0, 5);
    run_map(3, 2, 1'b0, 1'b1, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
